// File: rtl/pipeline_hazard_ctrl_pkg.sv
// cpu_pkg: opcode constants and scheduler FSM state encodings shared by the hazard controller.
package cpu_pkg;
   localparam logic [4:0] OP_LOAD_R = 5'b01010;
   localparam logic [4:0] OP_LOAD_I = 5'b01011;
   localparam logic [4:0] OP_JMP    = 5'b10011;
   localparam logic [4:0] OP_JNE    = 5'b10100;
   localparam logic [4:0] OP_JEQ    = 5'b10101;
   localparam logic [4:0] OP_MULT   = 5'b10110;
   localparam logic [4:0] OP_NOP    = 5'b10111;
   typedef enum logic [1:0] {RUN = 2'd0, MULT_WAIT = 2'd1, FLUSH = 2'd2} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX status in, pipeline stall/flush controls out.
// HAZARD_STATS_EN adds the stall/flush cycle counters.
interface pipeline_hazard_ctrl_if #(parameter int REG_ADDR_W = 4);
   logic                  id_valid;
   logic [4:0]            id_opcode;
   logic [REG_ADDR_W-1:0] id_rs_a;
   logic [REG_ADDR_W-1:0] id_rs_b;
   logic                  id_uses_b;
   logic                  ex_valid;
   logic [4:0]            ex_opcode;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  branch_taken;
   logic                  stall_pc;
   logic                  stall_id;
   logic                  hold_ex;
   logic                  bubble_ex;
   logic                  flush_if_id;
   logic                  mult_busy;
   logic [1:0]            ctrl_state;
`ifdef HAZARD_STATS_EN
   logic [15:0]           stall_cycles;
   logic [15:0]           flush_cycles;
   modport master(output id_valid, id_opcode, id_rs_a, id_rs_b, id_uses_b, ex_valid, ex_opcode,
                  ex_rd, branch_taken,
                  input stall_pc, stall_id, hold_ex, bubble_ex, flush_if_id, mult_busy,
                  ctrl_state, stall_cycles, flush_cycles);
   modport slave(input id_valid, id_opcode, id_rs_a, id_rs_b, id_uses_b, ex_valid, ex_opcode,
                 ex_rd, branch_taken,
                 output stall_pc, stall_id, hold_ex, bubble_ex, flush_if_id, mult_busy,
                 ctrl_state, stall_cycles, flush_cycles);
`else
   modport master(output id_valid, id_opcode, id_rs_a, id_rs_b, id_uses_b, ex_valid, ex_opcode,
                  ex_rd, branch_taken,
                  input stall_pc, stall_id, hold_ex, bubble_ex, flush_if_id, mult_busy,
                  ctrl_state);
   modport slave(input id_valid, id_opcode, id_rs_a, id_rs_b, id_uses_b, ex_valid, ex_opcode,
                 ex_rd, branch_taken,
                 output stall_pc, stall_id, hold_ex, bubble_ex, flush_if_id, mult_busy,
                 ctrl_state);
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl_down_counter.sv
// hazard_down_counter: 4-bit loadable down-counter with zero flag; stops at zero.
module hazard_down_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       zero
);
   always_ff @(posedge clk)
      if (reset) cnt <= 4'd0;
      else if (load) cnt <= load_val;
      else if (dec && !zero) cnt <= cnt - 4'd1;
   assign zero = cnt == 4'd0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy load-use / MULT / branch-flush scheduler for the decode pipeline.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_cycles counters.
module pipeline_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W     = 4,
   parameter int MULT_CYCLES    = 4,
   parameter int BRANCH_PENALTY = 2
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam logic [3:0] MC_LD = 4'(MULT_CYCLES - 2);
   localparam logic [3:0] BP_LD = 4'(BRANCH_PENALTY - 2);
   state_t     state, state_nx;
   logic       rst_q, blk, ld, dec, zero, load_use, ex_mult;
   logic [3:0] ld_val, cnt;
   // The cycle after reset is quiet as well: outputs masked and the FSM held in RUN.
   assign blk      = reset | rst_q;
   assign ex_mult  = bus.ex_valid && bus.ex_opcode == OP_MULT;
   assign load_use = bus.ex_valid && (bus.ex_opcode == OP_LOAD_R || bus.ex_opcode == OP_LOAD_I)
                     && bus.id_valid && (bus.id_rs_a == bus.ex_rd
                     || (bus.id_uses_b && bus.id_rs_b == bus.ex_rd));
   always_ff @(posedge clk)
      if (reset) begin
         state <= RUN;
         rst_q <= 1'b1;
      end else begin
         state <= state_nx;
         rst_q <= 1'b0;
      end
   hazard_down_counter u_cnt (
      .clk(clk), .reset(reset), .load(ld), .load_val(ld_val), .dec(dec), .cnt(cnt), .zero(zero)
   );
   always_comb begin
      state_nx        = state;
      ld              = 1'b0;
      ld_val          = MC_LD;
      dec             = 1'b0;
      bus.stall_pc    = 1'b0;
      bus.stall_id    = 1'b0;
      bus.hold_ex     = 1'b0;
      bus.bubble_ex   = 1'b0;
      bus.flush_if_id = 1'b0;
      bus.mult_busy   = 1'b0;
      if (!blk)
         case (state)
            RUN:
               if (bus.branch_taken) begin
                  bus.flush_if_id = 1'b1;
                  bus.bubble_ex   = 1'b1;
                  if (BRANCH_PENALTY > 1) begin
                     state_nx = FLUSH;
                     ld       = 1'b1;
                     ld_val   = BP_LD;
                  end
               end else if (ex_mult) begin
                  {bus.stall_pc, bus.stall_id, bus.hold_ex, bus.mult_busy} = 4'hF;
                  if (MULT_CYCLES > 2) begin
                     state_nx = MULT_WAIT;
                     ld       = 1'b1;
                  end
               end else if (load_use)
                  {bus.stall_pc, bus.stall_id, bus.bubble_ex} = 3'b111;
            // The detect cycle already holds once, so leaving at cnt==1 gives MULT_CYCLES-1 total.
            MULT_WAIT: begin
               {bus.stall_pc, bus.stall_id, bus.hold_ex, bus.mult_busy} = 4'hF;
               dec      = 1'b1;
               state_nx = cnt <= 4'd1 ? RUN : MULT_WAIT;
            end
            FLUSH: begin
               bus.flush_if_id = 1'b1;
               ld              = bus.branch_taken;
               ld_val          = BP_LD;
               dec             = !bus.branch_taken;
               state_nx        = !bus.branch_taken && zero ? RUN : FLUSH;
            end
            default: state_nx = RUN;
         endcase
   end
   assign bus.ctrl_state = reset ? 2'd0 : state;
   a_no_branch_in_mult: assert property (@(posedge clk) disable iff (blk)
      state == MULT_WAIT |-> !bus.branch_taken);
`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk)
      if (reset) begin
         bus.stall_cycles <= 16'd0;
         bus.flush_cycles <= 16'd0;
      end else begin
         bus.stall_cycles <= bus.stall_cycles + 16'(bus.stall_pc && bus.stall_cycles != 16'hFFFF);
         bus.flush_cycles <= bus.flush_cycles + 16'(bus.flush_if_id && bus.flush_cycles != 16'hFFFF);
      end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a queue scoreboard for pipeline_hazard_ctrl.
// Expected word: {stall_pc, stall_id, hold_ex, bubble_ex, flush_if_id, mult_busy, ctrl_state}.
module tb_pipeline_hazard_ctrl;
   import cpu_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];
   string      nm_q[$];
   localparam logic [7:0] Z     = 8'b000000_00;
   localparam logic [7:0] LU    = 8'b110100_00;
   localparam logic [7:0] MDET  = 8'b111001_00;
   localparam logic [7:0] MW    = 8'b111001_01;
   localparam logic [7:0] BR    = 8'b000110_00;
   localparam logic [7:0] FL    = 8'b000010_10;
   localparam logic [4:0] OP_ADD = 5'b00001;
   pipeline_hazard_ctrl_if #(.REG_ADDR_W(4)) bus ();
   pipeline_hazard_ctrl #(.REG_ADDR_W(4), .MULT_CYCLES(4), .BRANCH_PENALTY(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic cyc(input logic rst, input logic idv, input logic [3:0] ra, input logic [3:0] rb,
                      input logic ub, input logic exv, input logic [4:0] exop,
                      input logic [3:0] rd, input logic bt, input logic [7:0] e, input string nm);
      @(posedge clk);
      #1;
      reset            = rst;
      bus.id_valid     = idv;
      bus.id_opcode    = OP_ADD;
      bus.id_rs_a      = ra;
      bus.id_rs_b      = rb;
      bus.id_uses_b    = ub;
      bus.ex_valid     = exv;
      bus.ex_opcode    = exop;
      bus.ex_rd        = rd;
      bus.branch_taken = bt;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask
   task automatic cyc_rand(input logic rst, input string nm);
      @(posedge clk);
      #1;
      reset            = rst;
      bus.id_valid     = 1'($urandom);
      bus.id_opcode    = 5'($urandom);
      bus.id_rs_a      = 4'($urandom);
      bus.id_rs_b      = 4'($urandom);
      bus.id_uses_b    = 1'($urandom);
      bus.ex_valid     = 1'($urandom);
      bus.ex_opcode    = 5'($urandom);
      bus.ex_rd        = 4'($urandom);
      bus.branch_taken = 1'($urandom);
      exp_q.push_back(Z);
      nm_q.push_back(nm);
   endtask
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         logic [7:0] e, a;
         string      n;
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         a = {bus.stall_pc, bus.stall_id, bus.hold_ex, bus.bubble_ex, bus.flush_if_id,
              bus.mult_busy, bus.ctrl_state};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
         end
      end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cyc_rand(1, "reset_hold");
      cyc_rand(0, "post_reset");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "idle");
      cyc(0, 1, 3, 0, 0, 1, OP_LOAD_R, 3, 0, LU,   "lu_rs_a");
      cyc(0, 1, 3, 0, 0, 0, OP_NOP,    0, 0, Z,    "lu_after_bubble");
      cyc(0, 1, 5, 3, 0, 1, OP_LOAD_R, 3, 0, Z,    "lu_rs_b_unused");
      cyc(0, 1, 5, 3, 1, 1, OP_LOAD_I, 3, 0, LU,   "lu_rs_b_used");
      cyc(0, 1, 3, 0, 0, 0, OP_LOAD_R, 3, 0, Z,    "lu_ex_invalid");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MDET, "mult_detect");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MW,   "mult_wait1");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MW,   "mult_wait2");
      cyc(0, 1, 1, 2, 0, 0, OP_NOP,    0, 0, Z,    "mult_done");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MDET, "mult2_detect");
      cyc(1, 1, 1, 2, 0, 1, OP_MULT,   7, 0, Z,    "mult_reset_abort");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, Z,    "mult_post_reset");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "idle2");
      cyc(0, 0, 0, 0, 0, 1, OP_JEQ,    0, 1, BR,   "br_take");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, FL,   "br_flush");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "br_done");
      cyc(0, 0, 0, 0, 0, 1, OP_JMP,    0, 1, BR,   "br2_take");
      cyc(0, 0, 0, 0, 0, 1, OP_JNE,    0, 1, FL,   "br2_retrigger");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, FL,   "br2_extra_flush");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "br2_done");
      cyc(0, 1, 3, 0, 0, 1, OP_LOAD_R, 3, 1, BR,   "lu_vs_branch");
      cyc(0, 1, 3, 0, 0, 0, OP_NOP,    0, 0, FL,   "lu_vs_branch_flush");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "lu_vs_branch_done");
`ifdef HAZARD_STATS_EN
      cyc(1, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "st_reset");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "st_post_reset");
      cyc(0, 1, 3, 0, 0, 1, OP_LOAD_R, 3, 0, LU,   "st_lu");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MDET, "st_mult_detect");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MW,   "st_mult_wait1");
      cyc(0, 1, 1, 2, 0, 1, OP_MULT,   7, 0, MW,   "st_mult_wait2");
      cyc(0, 0, 0, 0, 0, 1, OP_JEQ,    0, 1, BR,   "st_br");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, FL,   "st_flush");
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "st_idle");
      @(negedge clk);
      checks += 2;
      if (bus.stall_cycles !== 16'd4) begin
         errors++;
         $display("FAIL stall_cycles: got %0d expected 4", bus.stall_cycles);
      end
      if (bus.flush_cycles !== 16'd2) begin
         errors++;
         $display("FAIL flush_cycles: got %0d expected 2", bus.flush_cycles);
      end
      cyc(0, 1, 3, 0, 0, 1, OP_LOAD_R, 3, 0, LU,   "st_sat_start");
      for (int i = 0; i < 65540; i++) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.stall_cycles !== 16'hFFFF) begin
         errors++;
         $display("FAIL stall_saturate: got %h expected ffff", bus.stall_cycles);
      end
      cyc(0, 0, 0, 0, 0, 0, OP_NOP,    0, 0, Z,    "st_sat_end");
`endif
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
